// File: rtl/mem_rsp_unit_if.sv
// Client-to-memory handshake bundle: level req with held address/data, one-cycle gnt/valid/err pulses.
interface mem_rsp_unit_if;
    logic        rd_req;
    logic [31:0] rd_addr;
    logic        rd_gnt;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        wr_req;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        wr_gnt;
    logic        err;

    modport master (
        output rd_req, rd_addr, wr_req, wr_addr, wr_data,
        input  rd_gnt, rd_valid, rd_data, wr_gnt, err
    );

    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_data,
        output rd_gnt, rd_valid, rd_data, wr_gnt, err
    );
endinterface

// File: rtl/mem_rsp_unit.sv
// Word-addressed local memory responder; read data one cycle after rd_gnt, write commits at wr_gnt.
// Requests are only sampled in IDLE, so a client simply holds req until it sees its grant.
module mem_rsp_unit #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    mem_rsp_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        RD_DATA,
        WR_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic            legal_q, legal_d;
    logic            last_wr_q, last_wr_d;
    logic            rd_gnt_q, rd_gnt_d;
    logic            rd_valid_q, rd_valid_d;
    logic [31:0]     rd_data_q, rd_data_d;
    logic            wr_gnt_q, wr_gnt_d;
    logic            err_q, err_d;

    logic            grant_rd;
    logic            grant_wr;
    logic            mem_we;
    logic            rd_legal;
    logic            wr_legal;

    logic [31:0]     mem [DEPTH];

    function automatic logic addr_legal(input logic [31:0] addr);
        return (addr[1:0] == 2'b00) && (addr[31:AW+2] == '0);
    endfunction

    assign rd_legal = addr_legal(bus.rd_addr);
    assign wr_legal = addr_legal(bus.wr_addr);

    // Round-robin only matters under contention: the read wins unless it won last time.
    assign grant_rd = bus.rd_req && (!bus.wr_req || last_wr_q);
    assign grant_wr = bus.wr_req && !grant_rd;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        legal_d    = legal_q;
        last_wr_d  = last_wr_q;
        rd_gnt_d   = 1'b0;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        wr_gnt_d   = 1'b0;
        err_d      = 1'b0;
        mem_we     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (grant_rd) begin
                    idx_d     = bus.rd_addr[AW+1:2];
                    legal_d   = rd_legal;
                    rd_gnt_d  = 1'b1;
                    last_wr_d = 1'b0;
                    state_d   = RD_DATA;
                end else if (grant_wr) begin
                    // Gated by rst_n so a write cannot land while reset is held.
                    mem_we    = wr_legal && rst_n;
                    wr_gnt_d  = 1'b1;
                    err_d     = !wr_legal;
                    last_wr_d = 1'b1;
                    state_d   = WR_DONE;
                end
            end
            RD_DATA: begin
                rd_valid_d = 1'b1;
                rd_data_d  = legal_q ? mem[idx_q] : 32'h0;
                err_d      = !legal_q;
                state_d    = IDLE;
            end
            WR_DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            legal_q    <= 1'b0;
            last_wr_q  <= 1'b1;
            rd_gnt_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= 32'h0;
            wr_gnt_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            legal_q    <= legal_d;
            last_wr_q  <= last_wr_d;
            rd_gnt_q   <= rd_gnt_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            wr_gnt_q   <= wr_gnt_d;
            err_q      <= err_d;
        end
    end

    // Storage has no reset; contents survive rst_n.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[bus.wr_addr[AW+1:2]] <= bus.wr_data;
        end
    end

    assign bus.rd_gnt   = rd_gnt_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.wr_gnt   = wr_gnt_q;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_mem_rsp_unit.sv
// Directed bench for mem_rsp_unit: basic read/write, hold, reset mid-transaction, contention, illegal access, full sweep.
module tb_mem_rsp_unit;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    mem_rsp_unit_if bus();

    mem_rsp_unit #(.DEPTH(256), .AW(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic exp_err);
        int n;
        n = 0;
        bus.wr_req  = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        do begin
            tick();
            n++;
        end while (!bus.wr_gnt && n < 8);
        check("wr_wait", n, 1);
        check("wr_err", 32'(bus.err), 32'(exp_err));
        check("wr_no_rdv", 32'(bus.rd_valid), 0);
        bus.wr_req = 1'b0;
        tick();
        check("wr_gnt_drop", 32'(bus.wr_gnt), 0);
        check("wr_err_drop", 32'(bus.err), 0);
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] exp_d, input logic exp_err);
        int n;
        n = 0;
        bus.rd_req  = 1'b1;
        bus.rd_addr = a;
        do begin
            tick();
            n++;
        end while (!bus.rd_gnt && n < 8);
        check("rd_wait", n, 1);
        check("rd_gnt_novld", 32'(bus.rd_valid), 0);
        bus.rd_req = 1'b0;
        tick();
        check("rd_valid", 32'(bus.rd_valid), 1);
        check("rd_gnt_drop", 32'(bus.rd_gnt), 0);
        check("rd_data", bus.rd_data, exp_d);
        check("rd_err", 32'(bus.err), 32'(exp_err));
    endtask

    initial begin
        logic [7:0] exp_rg;
        logic [7:0] exp_rv;
        logic [7:0] exp_wg;
        int         n;

        n_tests     = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        bus.rd_req  = 1'b0;
        bus.rd_addr = 32'h0;
        bus.wr_req  = 1'b0;
        bus.wr_addr = 32'h0;
        bus.wr_data = 32'h0;

        tick();
        tick();
        check("rst_rd_gnt", 32'(bus.rd_gnt), 0);
        check("rst_rd_valid", 32'(bus.rd_valid), 0);
        check("rst_rd_data", bus.rd_data, 0);
        check("rst_wr_gnt", 32'(bus.wr_gnt), 0);
        check("rst_err", 32'(bus.err), 0);
        rst_n = 1'b1;

        // Write then read back the same word.
        do_write(32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
        do_read(32'h0000_0010, 32'hDEAD_BEEF, 1'b0);

        // rd_data holds between pulses, even across a write.
        tick();
        check("hold_rdv_low", 32'(bus.rd_valid), 0);
        check("hold_data0", bus.rd_data, 32'hDEAD_BEEF);
        do_write(32'h0000_0018, 32'h1111_2222, 1'b0);
        check("hold_data1", bus.rd_data, 32'hDEAD_BEEF);

        // Reset while in RD_DATA: the pending rd_valid must never appear.
        bus.rd_req  = 1'b1;
        bus.rd_addr = 32'h0000_0010;
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.rd_gnt && n < 8);
        check("rstrd_wait", n, 1);
        bus.rd_req = 1'b0;
        rst_n      = 1'b0;
        #1;
        check("rstrd_gnt", 32'(bus.rd_gnt), 0);
        check("rstrd_data", bus.rd_data, 0);
        tick();
        check("rstrd_vld0", 32'(bus.rd_valid), 0);
        tick();
        check("rstrd_vld1", 32'(bus.rd_valid), 0);
        rst_n = 1'b1;
        do_read(32'h0000_0010, 32'hDEAD_BEEF, 1'b0);

        // Reset right after a write grant: the committed word survives.
        bus.wr_req  = 1'b1;
        bus.wr_addr = 32'h0000_0014;
        bus.wr_data = 32'h0000_CAFE;
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.wr_gnt && n < 8);
        check("rstwr_wait", n, 1);
        bus.wr_req = 1'b0;
        rst_n      = 1'b0;
        #1;
        check("rstwr_gnt", 32'(bus.wr_gnt), 0);
        tick();
        rst_n = 1'b1;
        do_read(32'h0000_0014, 32'h0000_CAFE, 1'b0);

        // Contention straight after reset: read first, then alternating.
        do_write(32'h0000_0020, 32'hAAAA_0001, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_rg = 8'b0001_0001;
        exp_rv = 8'b0010_0010;
        exp_wg = 8'b0100_0100;
        bus.rd_req  = 1'b1;
        bus.rd_addr = 32'h0000_0020;
        bus.wr_req  = 1'b1;
        bus.wr_addr = 32'h0000_0020;
        bus.wr_data = 32'hBBBB_0002;
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("arb_rg%0d", i), 32'(bus.rd_gnt), 32'(exp_rg[i]));
            check($sformatf("arb_rv%0d", i), 32'(bus.rd_valid), 32'(exp_rv[i]));
            check($sformatf("arb_wg%0d", i), 32'(bus.wr_gnt), 32'(exp_wg[i]));
            if (exp_rv[i])
                check($sformatf("arb_rd%0d", i), bus.rd_data,
                      (i == 1) ? 32'hAAAA_0001 : 32'hBBBB_0002);
        end
        bus.rd_req = 1'b0;
        bus.wr_req = 1'b0;
        tick();

        // Full sweep, with illegal writes in between that must not disturb anything.
        for (int i = 0; i < 256; i++)
            do_write(32'(i * 4), 32'(i), 1'b0);
        do_write(32'h0000_0400, 32'hFFFF_FFFF, 1'b1);
        do_write(32'h0000_0401, 32'hEEEE_EEEE, 1'b1);
        for (int i = 0; i < 256; i++)
            do_read(32'(i * 4), 32'(i), 1'b0);

        // Illegal reads return zero with err.
        do_read(32'h0000_0402, 32'h0, 1'b1);
        do_read(32'h0000_0400, 32'h0, 1'b1);
        do_read(32'h0000_0008, 32'h2, 1'b0);
        do_read(32'h8000_0004, 32'h0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_rsp_unit.md
MEM_RSP_UNIT -- requirements
Module: mem_rsp_unit

Parameters
REQ-001 SHALL provide parameter DEPTH, default 256, meaning number of 32-bit words in local storage (power of 2).
REQ-002 SHALL provide parameter AW, default 8, meaning word-index width, log2(DEPTH).

Interface
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 rd_req  input  1  read request; held high with rd_addr stable until rd_gnt seen.
REQ-006 rd_addr  input  32  read byte address.
REQ-007 rd_gnt  output  1  one-cycle pulse; read accepted.
REQ-008 rd_valid  output  1  one-cycle pulse; rd_data valid.
REQ-009 rd_data  output  32  read data.
REQ-010 wr_req  input  1  write request; held high with wr_addr/wr_data stable until wr_gnt seen.
REQ-011 wr_addr  input  32  write byte address.
REQ-012 wr_data  input  32  write data.
REQ-013 wr_gnt  output  1  one-cycle pulse; write committed.
REQ-014 err  output  1  one-cycle pulse; accepted access was misaligned or out of range.

Function
REQ-015 SHALL be the responder (memory side) for the client_read/client_write ports used by the FC and CNN engines.
REQ-016 SHALL hold DEPTH x 32-bit storage; word index = addr[AW+1:2].
REQ-017 Address legal iff addr[1:0]==0 and addr[31:AW+2]==0; otherwise illegal.
REQ-018 SHALL implement FSM states IDLE, RD_DATA, WR_DONE; all outputs registered.
REQ-019 IDLE, edge k, rd_req only: latch index, rd_gnt=1 during cycle k..k+1, go RD_DATA.
REQ-020 RD_DATA, edge k+1: rd_gnt=0, rd_valid=1, rd_data=mem[index] (0 if illegal), go IDLE; rd_valid=0 at edge k+2.
REQ-021 Read latency: rd_valid exactly one cycle after rd_gnt.
REQ-022 IDLE, edge k, wr_req only: write mem[index]=wr_data if legal, wr_gnt=1, go WR_DONE.
REQ-023 WR_DONE, edge k+1: wr_gnt=0, go IDLE.
REQ-024 Illegal write SHALL leave storage unchanged but still be granted.
REQ-025 err SHALL pulse coincident with rd_valid (illegal read) or wr_gnt (illegal write).
REQ-026 rd_req and wr_req both high in IDLE: round-robin via flag last_wr; grant read if last_wr==1, else write; flag updates on every grant.
REQ-027 Losing request SHALL stay pending and be granted at next IDLE sample (no starvation; max wait 3 cycles).
REQ-028 Requests SHALL be sampled only in IDLE; req levels in RD_DATA/WR_DONE ignored.
REQ-029 Write then read of same address SHALL return the new data (write commits before any later read grant).
REQ-030 rd_data SHALL hold last value between rd_valid pulses.
REQ-031 Throughput: one read per 2 cycles or one write per 2 cycles when client drops req on gnt.

Reset
REQ-032 rst_n low SHALL asynchronously force state IDLE, rd_gnt=0, rd_valid=0, rd_data=0, wr_gnt=0, err=0, last_wr=1.
REQ-033 Storage contents SHALL NOT be reset (undefined after power-up).
REQ-034 Reset mid-transaction SHALL drop pending rd_valid/wr_gnt; a write already committed at its grant edge remains.
REQ-035 First sample SHALL occur on first rising edge with rst_n high.

Verification
REQ-036 Write 0x0000_0010 <- 0xDEAD_BEEF, then read 0x10 -> wr_gnt 1 cycle; rd_gnt then rd_valid next cycle, rd_data=0xDEAD_BEEF, err=0.
REQ-037 rd_req and wr_req both raised same cycle after reset -> read granted first (last_wr=1), write granted at next IDLE; repeated contention alternates.
REQ-038 Read 0x0000_0402 (misaligned) and 0x0000_0400 (out of range, DEPTH=256) -> rd_data=0, err pulses with rd_valid; write to 0x400 leaves all words unchanged.
REQ-039 Assert rst_n low during RD_DATA -> rd_valid never pulses; outputs 0; next read after release served normally.
REQ-040 Back-to-back 256 writes then 256 reads of incrementing data 0..255 at addresses 0..0x3FC -> every rd_data matches, gnt/valid spacing per REQ-020/REQ-023.
